pu_wb: RTL and testbench

- Writeback stage directly upstream of the per-PID banked GPR file (pu_id_gpr); owns its single write port.
- Merges two result sources onto the one write port:
  - in-order EX/MEM pipeline results, buffered in a 2-entry FIFO with valid/ready backpressure;
  - late load returns, which have no backpressure and take priority.
- Applies per-PID flush and r0 write suppression.
- The registered write port doubles as the ID-stage forwarding source.

---
 rtl/pu_wb_pkg.sv | 24 ++
 rtl/pu_wb_fifo.sv | 72 +++++++
 rtl/pu_wb.sv | 106 ++++++++++
 tb/tb_pu_wb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_wb_pkg.sv
// Shared widths and slot layout for the pu_wb writeback stage.
package pu_wb_pkg;

  localparam int unsigned PID_NUM = 4;
  localparam int unsigned PID_W   = 2;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;

  typedef struct packed {
    logic              valid;
    logic [PID_W-1:0]  pid;
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic [DATA_W-1:0] data;
  } wb_slot_t;

  function automatic logic pid_hit(input logic fl_en, input logic [PID_W-1:0] a,
                                   input logic [PID_W-1:0] b);
    return fl_en && (a == b);
  endfunction

endpackage

// File: rtl/pu_wb_fifo.sv
// Two-entry circular buffer for pipeline results with a flush-by-pid valid clear.
module pu_wb_fifo
  import pu_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_slot_t         push_slot,
  input  logic             pop,
  input  logic             flush_en,
  input  logic [PID_W-1:0] flush_pid,
  output wb_slot_t         head,
  output logic [CNT_W-1:0] count
);

  wb_slot_t         slot_q [DEPTH];
  wb_slot_t         slot_d [DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ptr;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_d[1'(i)] = slot_q[1'(i)];
    end
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_ptr   = rd_ptr_q ^ count_q[0];

    // Flushed slots keep their place so ordering and occupancy are unaffected.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pid_hit(flush_en, slot_q[1'(i)].pid, flush_pid)) begin
        slot_d[1'(i)].valid = 1'b0;
      end
    end

    if (push) begin
      slot_d[wr_ptr]       = push_slot;
      slot_d[wr_ptr].valid = push_slot.valid && !pid_hit(flush_en, push_slot.pid, flush_pid);
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[1'(i)] <= '0;
      end
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[1'(i)] <= slot_d[1'(i)];
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = slot_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pu_wb.sv
// Writeback stage: merges load returns and buffered pipeline results onto the
// single GPR write port, which also serves as the ID-stage forwarding source.
module pu_wb
  import pu_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [PID_W-1:0]  ex_pid,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic              ex_en,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ld_valid,
  input  logic [PID_W-1:0]  ld_pid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              flush_en,
  input  logic [PID_W-1:0]  flush_pid,
  output logic [PID_W-1:0]  wr_pid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  occupancy
);

  wb_slot_t          beat, head, cand;
  logic [CNT_W-1:0]  count;
  logic              xfer, have_head, pop, push, bypass, cand_live, cand_ok;
  logic [PID_W-1:0]  wr_pid_q, wr_pid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Ready looks only at the stored count: a full buffer never accepts, even while popping.
  assign ex_ready = !rst && (count < CNT_W'(DEPTH));

  always_comb begin
    beat.valid = 1'b1;
    beat.pid   = ex_pid;
    beat.addr  = ex_addr;
    beat.en    = ex_en;
    beat.data  = ex_data;

    xfer      = ex_valid && ex_ready;
    have_head = (count != '0);
    pop       = !ld_valid && have_head;
    bypass    = !ld_valid && !have_head && xfer;
    push      = xfer && !bypass;
    cand      = have_head ? head : beat;
    cand_live = have_head || xfer;
    cand_ok   = cand.valid && !pid_hit(flush_en, cand.pid, flush_pid)
                && cand.en && (cand.addr != '0);

    wr_pid_d  = wr_pid_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;

    // Load returns cannot stall, so they always win the port.
    if (ld_valid) begin
      wr_pid_d  = ld_pid;
      wr_addr_d = ld_addr;
      wr_data_d = ld_data;
      wr_en_d   = (ld_addr != '0);
    end else if (cand_live) begin
      wr_pid_d  = cand.pid;
      wr_addr_d = cand.addr;
      wr_data_d = cand.data;
      wr_en_d   = cand_ok;
    end
  end

  pu_wb_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_slot (beat),
    .pop       (pop),
    .flush_en  (flush_en),
    .flush_pid (flush_pid),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pid_q  <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_pid_q  <= wr_pid_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_pid    = wr_pid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign occupancy = count;

endmodule

// File: tb/tb_pu_wb.sv
// Randomized scoreboard bench for pu_wb with a queue-based reference model.
module tb_pu_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_en = 1'b0, ld_valid = 1'b0, flush_en = 1'b0;
  logic        ex_ready, wr_en;
  logic [1:0]  ex_pid = '0, ld_pid = '0, flush_pid = '0, wr_pid, occupancy;
  logic [4:0]  ex_addr = '0, ld_addr = '0, wr_addr;
  logic [31:0] ex_data = '0, ld_data = '0, wr_data;

  always #5 clk = ~clk;

  pu_wb dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pid(ex_pid), .ex_addr(ex_addr),
    .ex_en(ex_en), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_pid(ld_pid), .ld_addr(ld_addr), .ld_data(ld_data),
    .flush_en(flush_en), .flush_pid(flush_pid),
    .wr_pid(wr_pid), .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
    .occupancy(occupancy)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  pid;
    logic [4:0]  addr;
    logic        en;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    int          stamp;
    logic [1:0]  pid;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  ent_t        mq[$];
  wr_t         eq[$];
  int          cyc = 0;
  logic [1:0]  m_pid = '0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          checks = 0;
  int          errors = 0;
  logic        acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_write(input logic [1:0] p, input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.stamp = cyc; w.pid = p; w.addr = a; w.data = d;
    eq.push_back(w);
  endtask

  // Reference model: one step per clock edge, in terms of a result queue.
  task automatic model_step();
    ent_t b, h;
    logic rdy, xf;
    if (rst) begin
      mq.delete(); eq.delete();
      m_pid = '0; m_addr = '0; m_data = '0;
      return;
    end
    cyc++;
    rdy = (mq.size() < 2);
    xf  = ex_valid && rdy;
    b.valid = !(flush_en && ex_pid == flush_pid);
    b.pid = ex_pid; b.addr = ex_addr; b.en = ex_en; b.data = ex_data;
    foreach (mq[i]) if (flush_en && mq[i].pid == flush_pid) mq[i].valid = 1'b0;
    if (ld_valid) begin
      m_pid = ld_pid; m_addr = ld_addr; m_data = ld_data;
      if (ld_addr != 0) expect_write(ld_pid, ld_addr, ld_data);
      if (xf) mq.push_back(b);
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_pid = h.pid; m_addr = h.addr; m_data = h.data;
      if (h.valid && h.en && h.addr != 0) expect_write(h.pid, h.addr, h.data);
      if (xf) mq.push_back(b);
    end else if (xf) begin
      m_pid = b.pid; m_addr = b.addr; m_data = b.data;
      if (b.valid && b.en && b.addr != 0) expect_write(b.pid, b.addr, b.data);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Monitor: compare the registered port and flow-control against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      logic exp_en;
      wr_t  w;
      exp_en = (eq.size() > 0) && (eq[0].stamp == cyc);
      chk("ex_ready", 32'(ex_ready), 32'(mq.size() < 2));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("wr_en", 32'(wr_en), 32'(exp_en));
      if (exp_en) begin
        w = eq.pop_front();
        chk("wr_pid", 32'(wr_pid), 32'(w.pid));
        chk("wr_addr", 32'(wr_addr), 32'(w.addr));
        chk("wr_data", wr_data, w.data);
      end else begin
        chk("hold_pid", 32'(wr_pid), 32'(m_pid));
        chk("hold_addr", 32'(wr_addr), 32'(m_addr));
        chk("hold_data", wr_data, m_data);
      end
    end
  end

  task automatic tick();
    acc = ex_valid && ex_ready;
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic v, input logic [1:0] p, input logic [4:0] a,
                        input logic e, input logic [31:0] d);
    ex_valid = v; ex_pid = p; ex_addr = a; ex_en = e; ex_data = d;
  endtask

  task automatic set_ld(input logic v, input logic [1:0] p, input logic [4:0] a,
                        input logic [31:0] d);
    ld_valid = v; ld_pid = p; ld_addr = a; ld_data = d;
  endtask

  task automatic idle(input int n);
    set_ex(1'b0, '0, '0, 1'b0, '0);
    set_ld(1'b0, '0, '0, '0);
    flush_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int ld_run;
    bit got;

    // Reset then idle.
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ex_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_pid", 32'(wr_pid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle(3);

    // Bypass through an empty buffer.
    set_ex(1'b1, 2'd2, 5'd5, 1'b1, 32'hDEADBEEF);
    tick();
    set_ex(1'b0, '0, '0, 1'b0, '0);
    chk("bypass_en", 32'(wr_en), 32'd1);
    chk("bypass_data", wr_data, 32'hDEADBEEF);
    chk("bypass_occ", 32'(occupancy), 32'd0);
    idle(2);

    // Load priority and backpressure.
    set_ld(1'b1, 2'd1, 5'd7, 32'h1111_0001);
    set_ex(1'b1, 2'd3, 5'd10, 1'b1, 32'hA);
    tick();
    set_ld(1'b1, 2'd1, 5'd7, 32'h1111_0002);
    set_ex(1'b1, 2'd3, 5'd11, 1'b1, 32'hB);
    tick();
    set_ld(1'b1, 2'd1, 5'd7, 32'h1111_0003);
    set_ex(1'b1, 2'd3, 5'd12, 1'b1, 32'hC);
    chk("bp_ready_full", 32'(ex_ready), 32'd0);
    tick();
    set_ld(1'b0, '0, '0, '0);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      got = acc;
    end
    if (!got) chk("bp_c_accept_timeout", 32'd0, 32'd1);
    idle(4);

    // Flush one thread while the buffer is held full by loads.
    set_ld(1'b1, 2'd2, 5'd1, 32'h2222);
    set_ex(1'b1, 2'd0, 5'd3, 1'b1, 32'h30);
    tick();
    set_ex(1'b1, 2'd1, 5'd4, 1'b1, 32'h41);
    tick();
    set_ex(1'b0, '0, '0, 1'b0, '0);
    flush_en = 1'b1; flush_pid = 2'd0;
    tick();
    flush_en = 1'b0;
    set_ld(1'b0, '0, '0, '0);
    chk("flush_occ", 32'(occupancy), 32'd2);
    tick();
    chk("flush_pop0_en", 32'(wr_en), 32'd0);
    tick();
    chk("flush_pop1_en", 32'(wr_en), 32'd1);
    chk("flush_pop1_addr", 32'(wr_addr), 32'd4);
    idle(2);

    // r0 and non-writing results.
    set_ex(1'b1, 2'd1, 5'd0, 1'b1, 32'h55);
    tick();
    chk("r0_en", 32'(wr_en), 32'd0);
    set_ex(1'b1, 2'd1, 5'd9, 1'b0, 32'h66);
    tick();
    chk("en0_en", 32'(wr_en), 32'd0);
    chk("en0_ready", 32'(ex_ready), 32'd1);
    idle(2);

    // Async reset mid-stream with a full buffer and a live write.
    set_ld(1'b1, 2'd3, 5'd2, 32'h7777);
    set_ex(1'b1, 2'd2, 5'd6, 1'b1, 32'h61);
    tick();
    set_ex(1'b1, 2'd2, 5'd8, 1'b1, 32'h81);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_ready", 32'(ex_ready), 32'd0);
    set_ex(1'b0, '0, '0, 1'b0, '0);
    set_ld(1'b0, '0, '0, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    idle(4);

    // Randomized traffic with valid/ready hold and bounded load bursts.
    ld_run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ex_valid || acc) begin
        if ($urandom_range(0, 9) < 6)
          set_ex(1'b1, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 ($urandom_range(0, 7) != 0), $urandom);
        else
          set_ex(1'b0, '0, '0, 1'b0, '0);
      end
      if (ld_run < 3 && $urandom_range(0, 9) < 3) begin
        set_ld(1'b1, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
        ld_run++;
      end else begin
        set_ld(1'b0, '0, '0, '0);
        ld_run = 0;
      end
      flush_en  = ($urandom_range(0, 9) == 0);
      flush_pid = 2'($urandom_range(0, 3));
      tick();
    end
    idle(6);
    chk("drain", 32'(eq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
